// File: rtl/pcileech_com_tx_gearbox.sv
// pcileech_com_tx_gearbox
//
// Transmit-direction width converter between FIFO control and the FT601
// write path. 256-bit words are written into a two-slot buffer and leave
// as eight 32-bit beats, lowest beat first, on a valid/ready stream.
// The block also drives a stretched TX-activity LED, a wrapping count of
// accepted beats and a sticky overflow flag.
//
// Ports:
//   clk              FT601 clock (ft601_clk)
//   rst              synchronous active-high reset
//   din              256-bit transmit word, bits [31:0] leave first
//   din_wr_en        write strobe, only honoured while din_ready is high
//   din_ready        buffer has a free slot this cycle
//   dout             current 32-bit beat (zero while not valid)
//   dout_valid       dout holds a beat
//   dout_ready       downstream takes the beat this cycle
//   led_state_invert XORed onto the LED output
//   led_state_txdata stretched TX-activity indicator
//   words_sent       number of accepted beats, wraps
//   err_overflow     sticky, a strobe arrived while the buffer was full

module pcileech_com_tx_gearbox #(
    parameter int PARAM_LED_STRETCH_BITS = 24
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [255:0]                     din,
    input  logic                             din_wr_en,
    output logic                             din_ready,
    output logic [31:0]                      dout,
    output logic                             dout_valid,
    input  logic                             dout_ready,
    input  logic                             led_state_invert,
    output logic                             led_state_txdata,
    output logic [31:0]                      words_sent,
    output logic                             err_overflow
);

    logic [255:0]                      slot0_q;
    logic [255:0]                      slot1_q;
    logic                              head_q;
    logic [1:0]                        count_q;
    logic [2:0]                        beat_q;
    logic [31:0]                       words_sent_q;
    logic                              err_overflow_q;
    logic [PARAM_LED_STRETCH_BITS-1:0] stretch_q;

    logic                              push;
    logic                              overflow_event;
    logic                              beat_accept;
    logic                              pop;
    logic                              tail;
    logic [255:0]                      head_word;

    // Handshake decode. The tail slot is the head while the buffer is
    // empty and the other slot while one word is held; with two words
    // held no push can happen, so tail is irrelevant then. rst gates
    // din_ready so a strobe during reset is neither stored nor flagged.
    always_comb begin
        din_ready      = (count_q != 2'd2) && !rst;
        dout_valid     = (count_q != 2'd0);
        push           = din_wr_en && din_ready;
        overflow_event = din_wr_en && !din_ready && !rst;
        beat_accept    = dout_valid && dout_ready;
        pop            = beat_accept && (beat_q == 3'd7);
        tail           = head_q ^ (count_q != 2'd0);
    end

    // Output mux: everything here comes from registers, so nothing on
    // the input side reaches dout or dout_valid combinationally.
    always_comb begin
        head_word = head_q ? slot1_q : slot0_q;
        dout      = 32'h0;
        if (dout_valid) begin
            dout = head_word[{beat_q, 5'd0} +: 32];
        end
        led_state_txdata = (stretch_q != '0) ^ led_state_invert;
    end

    // Buffer bookkeeping. A push and a pop in the same cycle leave the
    // count alone; when one word is held the pushed word lands in the
    // other slot, which the pop turns into the head, so there is no
    // bubble between words. beat_q wraps 7->0 on the popping beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot0_q <= '0;
            slot1_q <= '0;
            head_q  <= 1'b0;
            count_q <= 2'd0;
            beat_q  <= 3'd0;
        end else begin
            if (push) begin
                if (tail) begin
                    slot1_q <= din;
                end else begin
                    slot0_q <= din;
                end
            end
            if (push && !pop) begin
                count_q <= count_q + 2'd1;
            end else if (pop && !push) begin
                count_q <= count_q - 2'd1;
            end
            if (pop) begin
                head_q <= ~head_q;
            end
            if (beat_accept) begin
                beat_q <= beat_q + 3'd1;
            end
        end
    end

    // Status: beat counter, sticky overflow flag and the LED stretch
    // counter, which reloads on every accepted beat and otherwise runs
    // down to zero and stays there.
    always_ff @(posedge clk) begin
        if (rst) begin
            words_sent_q   <= 32'd0;
            err_overflow_q <= 1'b0;
            stretch_q      <= '0;
        end else begin
            if (beat_accept) begin
                words_sent_q <= words_sent_q + 32'd1;
            end
            if (overflow_event) begin
                err_overflow_q <= 1'b1;
            end
            if (beat_accept) begin
                stretch_q <= '1;
            end else if (stretch_q != '0) begin
                stretch_q <= stretch_q - PARAM_LED_STRETCH_BITS'(1);
            end
        end
    end

    assign words_sent   = words_sent_q;
    assign err_overflow = err_overflow_q;

endmodule

// File: tb/tb_pcileech_com_tx_gearbox.sv
// tb_pcileech_com_tx_gearbox
//
// Directed bench for pcileech_com_tx_gearbox with a 4-bit LED stretch
// counter. Inputs change and outputs are sampled on the falling edge,
// so each step below sees the state left by the preceding rising edge.

module tb_pcileech_com_tx_gearbox;

    logic         clk;
    logic         rst;
    logic [255:0] din;
    logic         din_wr_en;
    logic         din_ready;
    logic [31:0]  dout;
    logic         dout_valid;
    logic         dout_ready;
    logic         led_state_invert;
    logic         led_state_txdata;
    logic [31:0]  words_sent;
    logic         err_overflow;

    int vectors;
    int miscompares;

    pcileech_com_tx_gearbox #(
        .PARAM_LED_STRETCH_BITS(4)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .din              (din),
        .din_wr_en        (din_wr_en),
        .din_ready        (din_ready),
        .dout             (dout),
        .dout_valid       (dout_valid),
        .dout_ready       (dout_ready),
        .led_state_invert (led_state_invert),
        .led_state_txdata (led_state_txdata),
        .words_sent       (words_sent),
        .err_overflow     (err_overflow)
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Build a 256-bit word whose 32-bit lane i holds base + i.
    function automatic logic [255:0] make_word(input logic [31:0] base);
        logic [255:0] w;
        w = '0;
        for (int i = 0; i < 8; i++) begin
            w[32*i +: 32] = base + 32'(i);
        end
        return w;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic apply_stimulus(input logic wr, input logic [255:0] data, input logic rdy);
        din_wr_en  = wr;
        din        = data;
        dout_ready = rdy;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    logic [31:0] exp_q[$];
    logic [15:0] ready_pattern;
    int          pushed;
    int          model_words;
    logic        rdy;

    // Directed sequence: reset, single word, fill/block/overflow,
    // back-to-back words, pseudo-random stall, mid-operation reset,
    // LED stretch with both polarities, and the beat counter wrap.
    initial begin
        vectors          = 0;
        miscompares      = 0;
        rst              = 1'b1;
        led_state_invert = 1'b0;
        apply_stimulus(1'b0, '0, 1'b0);
        tick();
        tick();

        check_output("rst_din_ready", din_ready, 0);
        check_output("rst_valid", dout_valid, 0);
        check_output("rst_dout", dout, 0);
        check_output("rst_words", words_sent, 0);
        check_output("rst_err", err_overflow, 0);
        check_output("rst_led", led_state_txdata, 0);
        led_state_invert = 1'b1;
        #1;
        check_output("rst_led_inv", led_state_txdata, 1);
        led_state_invert = 1'b0;

        apply_stimulus(1'b1, make_word(32'h1234_0000), 1'b0);
        tick();
        check_output("rst_push_err", err_overflow, 0);
        check_output("rst_push_valid", dout_valid, 0);
        apply_stimulus(1'b0, '0, 1'b0);
        rst = 1'b0;
        #1;
        check_output("release_din_ready", din_ready, 1);

        // Single word, lanes 0..7.
        apply_stimulus(1'b1, make_word(32'h0), 1'b1);
        tick();
        din_wr_en = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check_output("single_valid", dout_valid, 1);
            check_output("single_dout", dout, 32'(k));
            tick();
        end
        check_output("single_done_valid", dout_valid, 0);
        check_output("single_words", words_sent, 8);

        // Fill both slots while stalled, then an overflow strobe.
        apply_stimulus(1'b1, make_word(32'hA000_0000), 1'b0);
        tick();
        apply_stimulus(1'b1, make_word(32'hB000_0000), 1'b0);
        tick();
        din_wr_en = 1'b0;
        check_output("full_din_ready", din_ready, 0);
        check_output("full_dout", dout, 32'hA000_0000);
        apply_stimulus(1'b1, make_word(32'hC000_0000), 1'b0);
        tick();
        din_wr_en = 1'b0;
        check_output("overflow_set", err_overflow, 1);
        tick();
        tick();
        check_output("stall_hold", dout, 32'hA000_0000);
        dout_ready = 1'b1;
        for (int j = 0; j < 16; j++) begin
            check_output("fill_dout", dout,
                         (j < 8) ? 32'hA000_0000 + 32'(j) : 32'hB000_0000 + 32'(j - 8));
            tick();
        end
        check_output("fill_done_valid", dout_valid, 0);
        check_output("overflow_sticky", err_overflow, 1);
        check_output("fill_words", words_sent, 24);

        // Back-to-back: E pushed on the edge that accepts D's last beat.
        apply_stimulus(1'b1, make_word(32'hD000_0000), 1'b1);
        tick();
        din_wr_en = 1'b0;
        for (int j = 0; j < 16; j++) begin
            check_output("b2b_valid", dout_valid, 1);
            check_output("b2b_dout", dout,
                         (j < 8) ? 32'hD000_0000 + 32'(j) : 32'hE000_0000 + 32'(j - 8));
            if (j == 7) begin
                check_output("b2b_din_ready", din_ready, 1);
                apply_stimulus(1'b1, make_word(32'hE000_0000), 1'b1);
            end
            tick();
            din_wr_en = 1'b0;
        end
        check_output("b2b_done_valid", dout_valid, 0);
        check_output("b2b_words", words_sent, 40);

        // Pseudo-random stall over ten words against a beat queue.
        ready_pattern = 16'b1011_0010_1110_0101;
        pushed        = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (pushed == 10 && exp_q.size() == 0) break;
            model_words = (exp_q.size() + 7) / 8;
            check_output("stall_valid", dout_valid, (exp_q.size() != 0) ? 1 : 0);
            check_output("stall_din_ready", din_ready, (model_words < 2) ? 1 : 0);
            if (exp_q.size() != 0) begin
                check_output("stall_dout", dout, exp_q[0]);
            end
            rdy = ready_pattern[cyc % 16];
            apply_stimulus(1'b0, '0, rdy);
            if (rdy && exp_q.size() != 0) begin
                void'(exp_q.pop_front());
            end
            if (pushed < 10 && model_words < 2 && (cyc % 4) != 1) begin
                apply_stimulus(1'b1, make_word(32'h5000_0000 + 32'(pushed << 8)), rdy);
                for (int i = 0; i < 8; i++) begin
                    exp_q.push_back(32'h5000_0000 + 32'(pushed << 8) + 32'(i));
                end
                pushed++;
            end
            tick();
        end
        din_wr_en = 1'b0;
        check_output("stall_all_pushed", 32'(pushed), 10);
        check_output("stall_drained", 32'(exp_q.size()), 0);
        check_output("stall_words", words_sent, 120);

        // Reset three beats into a word, with a push strobe alongside.
        apply_stimulus(1'b1, make_word(32'hF000_0000), 1'b1);
        tick();
        din_wr_en = 1'b0;
        tick();
        tick();
        tick();
        check_output("midrst_pre_dout", dout, 32'hF000_0003);
        rst = 1'b1;
        apply_stimulus(1'b1, make_word(32'h7700_0000), 1'b1);
        tick();
        check_output("midrst_valid", dout_valid, 0);
        check_output("midrst_dout", dout, 0);
        check_output("midrst_words", words_sent, 0);
        check_output("midrst_err", err_overflow, 0);
        check_output("midrst_din_ready", din_ready, 0);
        rst = 1'b0;
        apply_stimulus(1'b0, '0, 1'b1);
        #1;
        check_output("midrst_release_ready", din_ready, 1);
        apply_stimulus(1'b1, make_word(32'h6000_0000), 1'b1);
        tick();
        din_wr_en = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check_output("midrst_new_dout", dout, 32'h6000_0000 + 32'(k));
            tick();
        end
        check_output("midrst_new_words", words_sent, 8);

        // LED stretch: one accepted beat per polarity.
        dout_ready = 1'b0;
        for (int i = 0; i < 16; i++) tick();
        check_output("led_idle", led_state_txdata, 0);
        apply_stimulus(1'b1, make_word(32'h4000_0000), 1'b0);
        tick();
        din_wr_en = 1'b0;
        for (int inv = 0; inv < 2; inv++) begin
            led_state_invert = inv[0];
            dout_ready       = 1'b1;
            tick();
            dout_ready = 1'b0;
            for (int i = 0; i < 15; i++) begin
                check_output("led_on", led_state_txdata, inv[0] ? 0 : 1);
                tick();
            end
            check_output("led_off", led_state_txdata, inv[0] ? 1 : 0);
        end
        led_state_invert = 1'b0;
        check_output("led_words", words_sent, 10);
        check_output("led_dout", dout, 32'h4000_0002);

        // Counter wrap from a forced all-ones value.
        force dut.words_sent_q = 32'hFFFF_FFFF;
        #1;
        release dut.words_sent_q;
        #1;
        check_output("wrap_pre", words_sent, 32'hFFFF_FFFF);
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;
        check_output("wrap_post", words_sent, 0);
        check_output("wrap_dout", dout, 32'h4000_0003);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
